// File: rtl/me_pkg.sv
// Shared widths, types and coordinate helpers for the ME motion-vector collector.
// Signed motion vectors are always one bit wider than the search positions.
package me_pkg;

    localparam int SAD_W     = 14;
    localparam int POS_W     = 5;
    localparam int MV_OFFSET = 8;
    localparam int BLK_W     = 8;

    typedef logic signed [POS_W:0] mv_t;

    typedef struct packed {
        mv_t                mv_x;
        mv_t                mv_y;
        logic [SAD_W-1:0]   sad;
        logic [BLK_W-1:0]   blk;
        logic               intra;
    } mv_entry_t;

    function automatic logic pos_out_of_range(input logic [POS_W-1:0] pos);
        return pos > POS_W'(2 * MV_OFFSET);
    endfunction

    // Out-of-window positions saturate to the positive edge of the window.
    function automatic mv_t pos_to_mv(input logic [POS_W-1:0] pos);
        if (pos_out_of_range(pos)) begin
            return mv_t'(MV_OFFSET);
        end
        return mv_t'({1'b0, pos}) - mv_t'(MV_OFFSET);
    endfunction

endpackage

// File: rtl/me_sync_fifo.sv
// Generic show-ahead synchronous FIFO with occupancy count.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module me_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage is not reset: the read side is qualified by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/me_mv_collector.sv
// Collects ME per-block results, converts positions to signed MVs, queues them
// for the packing stage and keeps a saturating per-frame SAD total.
module me_mv_collector
    import me_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int INTRA_THRESH = 2048,
    parameter int FSAD_W       = 24,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SAD_W-1:0]        sad_i,
    input  logic [POS_W-1:0]        row_i,
    input  logic [POS_W-1:0]        col_i,
    input  logic                    valid_i,
    input  logic                    frame_start_i,
    output logic                    mv_valid_o,
    input  logic                    mv_ready_i,
    output logic signed [POS_W:0]   mv_x_o,
    output logic signed [POS_W:0]   mv_y_o,
    output logic [SAD_W-1:0]        mv_sad_o,
    output logic [BLK_W-1:0]        mv_blk_o,
    output logic                    mv_intra_o,
    output logic [CW-1:0]           count_o,
    output logic [FSAD_W-1:0]       frame_sad_o,
    output logic                    overflow_o,
    output logic                    range_err_o
);

    // Valid/ready: the head entry transfers on a rising edge where mv_valid_o
    // and mv_ready_i are both high; head fields hold while valid && !ready.

    logic                s1_valid;
    mv_entry_t           s1_entry;
    mv_entry_t           next_entry;
    mv_entry_t           head;
    logic [BLK_W-1:0]    blk_cnt;
    logic [BLK_W-1:0]    stage_blk;
    logic [FSAD_W-1:0]   fsad_base;
    logic [FSAD_W:0]     fsad_sum;
    logic [FSAD_W-1:0]   fsad_next;
    logic [FSAD_W:0]     sad_ext;
    logic                fifo_full;
    logic                fifo_empty;
    logic [$bits(mv_entry_t)-1:0] fifo_rdata;
    logic                drop;

    always_comb begin
        stage_blk        = frame_start_i ? '0 : blk_cnt;
        next_entry.mv_x  = pos_to_mv(col_i);
        next_entry.mv_y  = pos_to_mv(row_i);
        next_entry.sad   = sad_i;
        next_entry.blk   = stage_blk;
        next_entry.intra = (sad_i > SAD_W'(INTRA_THRESH));
        sad_ext          = {{(FSAD_W + 1 - SAD_W){1'b0}}, sad_i};
        fsad_base        = frame_start_i ? '0 : frame_sad_o;
        fsad_sum         = {1'b0, fsad_base} + sad_ext;
        fsad_next        = fsad_sum[FSAD_W] ? '1 : fsad_sum[FSAD_W-1:0];
    end

    // A full FIFO only admits the staged entry if the head leaves on the same edge.
    assign drop = s1_valid && fifo_full && !mv_ready_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid    <= 1'b0;
            s1_entry    <= '0;
            blk_cnt     <= '0;
            frame_sad_o <= '0;
            overflow_o  <= 1'b0;
            range_err_o <= 1'b0;
        end else begin
            s1_valid <= valid_i;
            if (valid_i) begin
                s1_entry    <= next_entry;
                blk_cnt     <= stage_blk + 1'b1;
                frame_sad_o <= fsad_next;
                if (pos_out_of_range(row_i) || pos_out_of_range(col_i)) begin
                    range_err_o <= 1'b1;
                end
            end else if (frame_start_i) begin
                blk_cnt     <= '0;
                frame_sad_o <= '0;
            end
            if (drop) begin
                overflow_o <= 1'b1;
            end
        end
    end

    me_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(mv_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s1_valid),
        .pop   (mv_ready_i),
        .wdata (s1_entry),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count_o)
    );

    assign head       = fifo_rdata;
    assign mv_valid_o = !fifo_empty;
    assign mv_x_o     = mv_valid_o ? head.mv_x  : '0;
    assign mv_y_o     = mv_valid_o ? head.mv_y  : '0;
    assign mv_sad_o   = mv_valid_o ? head.sad   : '0;
    assign mv_blk_o   = mv_valid_o ? head.blk   : '0;
    assign mv_intra_o = mv_valid_o ? head.intra : 1'b0;

endmodule

// File: doc/me_mv_collector.md
Name: me_mv_collector

Overview:
- Downstream consumer of the ME core's per-block result strobe (MSAD, MSAD_row, MSAD_column, data_valid).
- Converts search-window coordinates to signed motion vectors and tags each result with a block index and an intra flag.
- Buffers results in a FIFO with a valid/ready output for the entropy/packing stage, and accumulates a per-frame SAD total.
- ME has no backpressure, so this block must never stall its input. Overflow drops entries and flags the drop.

Parameters:
- SAD_W, 14, width of the SAD value (matches ME MSAD).
- POS_W, 5, width of the row/column search position.
- MV_OFFSET, 8, centre of the search window; mv = pos - MV_OFFSET; legal pos 0..2*MV_OFFSET.
- DEPTH, 8, FIFO entries (power of 2).
- BLK_W, 8, block index width.
- INTRA_THRESH, 2048, SAD strictly above this sets the intra flag.
- FSAD_W, 24, frame SAD accumulator width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- sad_i  in  SAD_W  MSAD from ME
- row_i  in  POS_W  MSAD_row from ME
- col_i  in  POS_W  MSAD_column from ME
- valid_i  in  1  ME data_valid; single-cycle strobe per result, no ready
- frame_start_i  in  1  pulse; restarts block index and frame SAD
- mv_valid_o  out  1  FIFO head valid
- mv_ready_i  in  1  consumer ready
- mv_x_o  out  POS_W+1  signed horizontal MV (col - MV_OFFSET)
- mv_y_o  out  POS_W+1  signed vertical MV (row - MV_OFFSET)
- mv_sad_o  out  SAD_W  SAD of head entry
- mv_blk_o  out  BLK_W  block index of head entry
- mv_intra_o  out  1  head SAD > INTRA_THRESH
- count_o  out  log2(DEPTH)+1  FIFO occupancy
- frame_sad_o  out  FSAD_W  saturating sum of SADs since frame_start
- overflow_o  out  1  sticky; at least one entry dropped
- range_err_o  out  1  sticky; row or col > 2*MV_OFFSET seen

Behaviour:
- Reset (rst=0, async): all outputs 0, FIFO empty, pointers/count 0, block index 0, stage register invalid.
- Stage 1, edge N where valid_i=1:
  - Capture sad, compute mv_x/mv_y (signed, POS_W+1 bits) and intra flag.
  - Assign the current block index, then increment it (wraps at 2^BLK_W).
  - Add SAD to frame_sad_o, saturating at all-ones.
- Stage 2, edge N+1: push to FIFO. mv_valid_o=1 after edge N+1 when the FIFO was empty, so input-to-output latency is 2 edges.
- Output is show-ahead: head fields are valid whenever mv_valid_o=1. Pop when mv_valid_o && mv_ready_i at a rising edge.
- Fields must stay stable while mv_valid_o=1 and mv_ready_i=0.
- Full:
  - Push with no pop in the same cycle: entry dropped, overflow_o set (sticky until reset), count unchanged.
  - Push with pop in the same cycle: both happen, no drop.
- Empty: pop ignored; mv_ready_i is don't-care.
- Back-to-back valid_i every cycle: every result is processed. Only FIFO capacity limits throughput.
- Range clamp: if row or col > 2*MV_OFFSET, clamp that component to +MV_OFFSET, set range_err_o (sticky), push the entry normally.
- frame_start_i:
  - Alone: block index := 0, frame_sad_o := 0 at the next edge.
  - With valid_i in the same cycle: that result gets index 0, and frame_sad_o := its SAD.
  - FIFO contents and sticky flags are not affected.
- Dropped entries still consume a block index and still count in frame_sad_o, so the consumer sees a gap in mv_blk_o.
- Reset mid-operation: FIFO is discarded immediately (async). No partial entries survive.

Decomposition:
- Package me_pkg:
  - SAD_W, POS_W, MV_OFFSET defaults.
  - Signed MV typedef mv_t (POS_W+1 bits).
  - Packed struct mv_entry_t {mv_x, mv_y, sad, blk, intra}.
- Sub-module me_sync_fifo:
  - Generic DEPTH x WIDTH, show-ahead.
  - Full/empty/count outputs.
  - Handles simultaneous push/pop when full.
  - Instantiated once with WIDTH = $bits(mv_entry_t).
- Top-level owns: stage register, conversion/clamp, block counter, frame SAD accumulator, sticky flags.

Test Plan:
- Reset release, one valid_i with sad=0x0123, row=8, col=8, ready=1 -> mv_valid_o high 2 edges later with mv_x=0, mv_y=0, sad=0x0123, blk=0, intra=0.
- row=0, col=16 with sad=0x0900 -> mv_y=-8, mv_x=+8, intra=1 (2304 > 2048); row=20 -> mv_y=+8, range_err_o=1.
- mv_ready_i=0, 10 consecutive valid_i strobes -> count_o=8, overflow_o=1, drain yields blk 0..7. Next accepted result has blk=10.
- FIFO full, valid_i and pop in the same cycle -> count_o stays 8, no overflow, new entry appears at tail.
- Sum three results sad=0x3FFF, then frame_start_i coincident with sad=5 -> frame_sad_o=0x00BFFD, then 0x000005 with blk=0. Force accumulator near 0xFFFFFF -> saturates.
- Assert rst low mid-drain with 4 entries queued -> mv_valid_o, count_o, and sticky flags go 0 without waiting for a clock edge.
